// File: rtl/montgomery_mul_arbiter.sv
// montgomery_mul_arbiter: round-robin share of one montgomery_mul among NREQ
// requesters, one operation in flight, registered result, done/timeout pulses.
// Ports: clk, rst (async, active-high); req/req_a/req_b/req_m/req_m_size per
// requester; grant, done_p, err_p, y to requesters; mm_* to/from the multiplier.
module montgomery_mul_arbiter #(
  parameter int NBITS  = 2048,
  parameter int NREQ   = 3,
  parameter int TOUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*NBITS-1:0]   req_a,
  input  logic [NREQ*NBITS-1:0]   req_b,
  input  logic [NREQ*NBITS-1:0]   req_m,
  input  logic [NREQ*12-1:0]      req_m_size,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done_p,
  output logic [NREQ-1:0]         err_p,
  output logic [NBITS-1:0]        y,
  output logic                    mm_enable_p,
  output logic [NBITS-1:0]        mm_a,
  output logic [NBITS-1:0]        mm_b,
  output logic [NBITS-1:0]        mm_m,
  output logic [11:0]             mm_m_size,
  input  logic [NBITS-1:0]        mm_y,
  input  logic                    mm_done_p
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = 1;
  // wdog value on the last BUSY cycle before it would wrap to all-ones
  localparam logic [TOUT_W-1:0] WD_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESP
  } state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     pick;
  logic              pick_vld;
  logic [PW-1:0]     nxt_ptr;
  logic [TOUT_W-1:0] wdog;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req[idx]) begin
        pick     = PW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign nxt_ptr = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      grant       <= '0;
      done_p      <= '0;
      err_p       <= '0;
      y           <= '0;
      mm_enable_p <= 1'b0;
      mm_a        <= '0;
      mm_b        <= '0;
      mm_m        <= '0;
      mm_m_size   <= '0;
      wdog        <= '0;
    end else begin
      done_p      <= '0;
      err_p       <= '0;
      mm_enable_p <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            owner     <= pick;
            grant     <= ONE << pick;
            mm_a      <= req_a[int'(pick)*NBITS +: NBITS];
            mm_b      <= req_b[int'(pick)*NBITS +: NBITS];
            mm_m      <= req_m[int'(pick)*NBITS +: NBITS];
            mm_m_size <= req_m_size[int'(pick)*12 +: 12];
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          mm_enable_p <= 1'b1;
          wdog        <= '0;
          state       <= BUSY;
        end
        BUSY: begin
          wdog <= wdog + 1'b1;
          // a completion on the final watchdog cycle still counts as done
          if (mm_done_p) begin
            y      <= mm_y;
            done_p <= grant;
            state  <= RESP;
          end else if (wdog == WD_LAST) begin
            err_p  <= grant;
            grant  <= '0;
            rr_ptr <= nxt_ptr;
            state  <= IDLE;
          end
        end
        RESP: begin
          grant  <= '0;
          rr_ptr <= nxt_ptr;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_mul_arbiter.sv
// tb_montgomery_mul_arbiter: directed vectors for montgomery_mul_arbiter
// with a stub multiplier (y = a + b, configurable latency).
module tb_montgomery_mul_arbiter;

  localparam int NB = 16;
  localparam int NR = 3;
  localparam int TW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req = '0;
  logic [NR*NB-1:0] req_a = '0;
  logic [NR*NB-1:0] req_b = '0;
  logic [NR*NB-1:0] req_m = {16'h3333, 16'h2222, 16'h1111};
  logic [NR*12-1:0] req_m_size = {12'd3, 12'd2, 12'd1};
  logic [NR-1:0]  grant, done_p, err_p;
  logic [NB-1:0]  y, mm_a, mm_b, mm_m, mm_y;
  logic [11:0]    mm_m_size;
  logic           mm_enable_p, mm_done_p;

  montgomery_mul_arbiter #(.NBITS(NB), .NREQ(NR), .TOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_a(req_a), .req_b(req_b), .req_m(req_m),
    .req_m_size(req_m_size),
    .grant(grant), .done_p(done_p), .err_p(err_p), .y(y),
    .mm_enable_p(mm_enable_p), .mm_a(mm_a), .mm_b(mm_b),
    .mm_m(mm_m), .mm_m_size(mm_m_size),
    .mm_y(mm_y), .mm_done_p(mm_done_p)
  );

  always #5 clk = ~clk;

  // stub multiplier
  int         stub_lat  = 6;
  bit         stub_hang = 1'b0;
  logic       stray     = 1'b0;
  logic [5:0] cnt;
  logic [NB-1:0] stub_res;
  logic       stub_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      stub_res  <= '0;
      stub_done <= 1'b0;
    end else begin
      stub_done <= 1'b0;
      if (mm_enable_p) begin
        cnt      <= 6'd1;
        stub_res <= mm_a + mm_b;
      end else if (cnt != 0) begin
        if (int'(cnt) == stub_lat - 1) begin
          stub_done <= !stub_hang;
          cnt       <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign mm_done_p = stub_done | stray;
  assign mm_y      = stray ? 16'hFFFF : stub_res;

  int launches = 0;
  always @(posedge clk) if (mm_enable_p) launches++;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_grant_wait"}, 32'(n < 50), 32'd1);
  endtask

  // waits for done_p or err_p; returns negedges taken
  task automatic wait_end(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_p == '0 && err_p == '0 && n < 100);
    chk({name, "_end_wait"}, 32'(n < 100), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [NR-1:0] r,
                        input logic [NR*NB-1:0] a,
                        input logic [NR*NB-1:0] b,
                        input logic [NR-1:0] eg, input logic [NB-1:0] ey,
                        input bit mutate);
    logic [NB-1:0] ea, eb, em;
    logic [11:0]   es;
    int            l0, n;
    ea = '0; eb = '0; em = '0; es = '0;
    for (int i = 0; i < NR; i++)
      if (eg[i]) begin
        ea = a[i*NB +: NB];
        eb = b[i*NB +: NB];
        em = req_m[i*NB +: NB];
        es = req_m_size[i*12 +: 12];
      end
    @(negedge clk);
    req = r; req_a = a; req_b = b;
    l0 = launches;
    wait_grant(name);
    chk({name, "_grant"}, 32'(grant), 32'(eg));
    chk({name, "_en_early"}, 32'(mm_enable_p), 32'd0);
    if (mutate) begin
      req_a = ~a;
      req_b = ~b;
    end
    @(negedge clk);
    chk({name, "_launch"}, 32'(mm_enable_p), 32'd1);
    chk({name, "_mm_a"}, 32'(mm_a), 32'(ea));
    chk({name, "_mm_b"}, 32'(mm_b), 32'(eb));
    chk({name, "_mm_m"}, 32'(mm_m), 32'(em));
    chk({name, "_mm_sz"}, 32'(mm_m_size), 32'(es));
    wait_end(name, n);
    chk({name, "_done"}, 32'(done_p), 32'(eg));
    chk({name, "_err"}, 32'(err_p), 32'd0);
    chk({name, "_y"}, 32'(y), 32'(ey));
    chk({name, "_nlaunch"}, 32'(launches - l0), 32'd1);
    if (mutate) begin
      req_a = a;
      req_b = b;
    end
  endtask

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*NB-1:0] a;
    logic [NR*NB-1:0] b;
    logic [NR-1:0]    grant;
    logic [NB-1:0]    y;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    logic [NR-1:0] acc;
    vecs[0] = '{3'b111, {16'h0300, 16'h0200, 16'h0100},
                {16'h0003, 16'h0002, 16'h0001}, 3'b001, 16'h0101};
    vecs[1] = '{3'b111, {16'h0300, 16'h0200, 16'h0100},
                {16'h0003, 16'h0002, 16'h0001}, 3'b010, 16'h0202};
    vecs[2] = '{3'b111, {16'h0300, 16'h0200, 16'h0100},
                {16'h0003, 16'h0002, 16'h0001}, 3'b100, 16'h0303};
    vecs[3] = '{3'b111, {16'h7000, 16'h8001, 16'hFF00},
                {16'h0007, 16'h8000, 16'h0100}, 3'b001, 16'h0000};
    vecs[4] = '{3'b111, {16'h7000, 16'h8001, 16'hFF00},
                {16'h0007, 16'h8000, 16'h0100}, 3'b010, 16'h0001};
    vecs[5] = '{3'b111, {16'h7000, 16'h8001, 16'hFF00},
                {16'h0007, 16'h8000, 16'h0100}, 3'b100, 16'h7007};
    vecs[6] = '{3'b010, {16'h0000, 16'h0003, 16'h0000},
                {16'h0000, 16'h0004, 16'h0000}, 3'b010, 16'h0007};
    vecs[7] = '{3'b101, {16'h00A0, 16'h1111, 16'h000A},
                {16'h0B00, 16'h2222, 16'h00B0}, 3'b100, 16'h0BA0};
    vecs[8] = '{3'b110, {16'h00A0, 16'h1111, 16'h000A},
                {16'h0B00, 16'h2222, 16'h00B0}, 3'b010, 16'h3333};
    vecs[9] = '{3'b011, {16'h00A0, 16'h1111, 16'h000A},
                {16'h0B00, 16'h2222, 16'h00B0}, 3'b001, 16'h00BA};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done_p), 32'd0);
    chk("rst_err", 32'(err_p), 32'd0);
    chk("rst_en", 32'(mm_enable_p), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_mm_a", 32'(mm_a), 32'd0);
    rst = 1'b0;

    // rotation from rr_ptr=0, then mixed request patterns
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].a, vecs[i].b,
             vecs[i].grant, vecs[i].y, 1'b0);
    // rr_ptr now 1: operands changed after grant are ignored
    run_op("latch", 3'b010, {16'h0, 16'h0003, 16'h0},
           {16'h0, 16'h0004, 16'h0}, 3'b010, 16'h0007, 1'b1);

    // rr_ptr 2: request dropped mid-BUSY still completes
    @(negedge clk);
    req = 3'b100;
    req_a = {16'h0010, 16'h0, 16'h0};
    req_b = {16'h0020, 16'h0, 16'h0};
    wait_grant("drop");
    chk("drop_grant", 32'(grant), 32'b100);
    @(negedge clk);
    req = '0;
    n = launches;
    wait_end("drop", n);
    chk("drop_done", 32'(done_p), 32'b100);
    chk("drop_y", 32'(y), 32'h0030);
    n = launches;
    acc = '0;
    repeat (6) begin
      @(negedge clk);
      acc |= grant;
    end
    chk("drop_nogrant", 32'(acc), 32'd0);
    chk("drop_nolaunch", 32'(launches - n), 32'd0);

    // stray mm_done_p while idle
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    acc = '0;
    repeat (4) begin
      @(negedge clk);
      acc |= done_p;
    end
    chk("stray_done", 32'(acc), 32'd0);
    chk("stray_y", 32'(y), 32'h0030);

    // rr_ptr 0: completion on the last watchdog cycle wins
    stub_lat = 30;
    run_op("edge", 3'b001, {16'h0, 16'h0, 16'h0001},
           {16'h0, 16'h0, 16'h0002}, 3'b001, 16'h0003, 1'b0);
    stub_lat = 6;

    // rr_ptr 1: multiplier never completes
    stub_hang = 1'b1;
    @(negedge clk);
    req = 3'b010;
    req_a = {16'h0, 16'h0005, 16'h0};
    req_b = {16'h0, 16'h0005, 16'h0};
    wait_grant("tout");
    chk("tout_grant", 32'(grant), 32'b010);
    @(negedge clk);
    chk("tout_launch", 32'(mm_enable_p), 32'd1);
    req = '0;
    wait_end("tout", n);
    chk("tout_cycles", 32'(n), 32'd31);
    chk("tout_err", 32'(err_p), 32'b010);
    chk("tout_done", 32'(done_p), 32'd0);
    chk("tout_y", 32'(y), 32'h0003);
    @(negedge clk);
    chk("tout_err_1cyc", 32'(err_p), 32'd0);
    chk("tout_ungrant", 32'(grant), 32'd0);
    stub_hang = 1'b0;
    // rr_ptr advanced past the timed-out owner
    run_op("tout_rr", 3'b111, {16'h0040, 16'h0020, 16'h0010},
           {16'h0004, 16'h0002, 16'h0001}, 3'b100, 16'h0044, 1'b0);

    // reset while BUSY
    @(negedge clk);
    req = 3'b001;
    req_a = {16'h0, 16'h0, 16'h0009};
    req_b = {16'h0, 16'h0, 16'h0001};
    wait_grant("rbusy");
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rbusy_grant", 32'(grant), 32'd0);
    chk("rbusy_y", 32'(y), 32'd0);
    chk("rbusy_mm_a", 32'(mm_a), 32'd0);
    chk("rbusy_en", 32'(mm_enable_p), 32'd0);
    chk("rbusy_de", 32'({done_p, err_p}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acc = '0;
    repeat (40) begin
      @(negedge clk);
      acc |= done_p | err_p | grant;
    end
    chk("rbusy_quiet", 32'(acc), 32'd0);
    // rr_ptr back to 0 after reset
    run_op("post_rst", 3'b111, {16'h0003, 16'h0002, 16'h0001},
           {16'h0030, 16'h0020, 16'h0010}, 3'b001, 16'h0011, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
